// File: rtl/stream_width_serializer_if.sv
// Stream interface for the width serializer.
// It carries the wide word input side (FWFT FIFO read port) and the narrow beat output side.
interface stream_width_serializer_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
);
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 out_ready;

    // Producer/consumer environment around the serializer.
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    // The serializer itself.
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/stream_width_serializer.sv
// Wide-to-narrow stream serializer.
// Holds one IN_WIDTH word and emits it as RATIO beats of OUT_WIDTH bits, least-significant slice first.
// A new word loads on the same edge the final beat leaves, so back-to-back words stream at one beat per cycle.
// IN_WIDTH must be an integer multiple of OUT_WIDTH, with at least two beats per word.
module stream_width_serializer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_width_serializer_if.slave s,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [CNT_WIDTH-1:0] beat_count,
    output logic                 busy
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   data_q, data_d;
    logic                  last_q, last_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic [CNT_WIDTH-1:0]  beat_count_q, beat_count_d;

    logic                  out_valid;
    logic                  at_last;
    logic                  out_xfer;
    logic                  in_ready;
    logic                  in_xfer;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_last;

    // Handshake decode; outputs are forced quiet while reset is asserted so nothing leaks during reset.
    always_comb begin
        out_valid = rst && (state_q == SHIFT);
        at_last   = (idx_q == LAST_IDX);
        out_xfer  = out_valid && s.out_ready;
        in_ready  = rst && ((state_q == IDLE) || (out_xfer && at_last));
        in_xfer   = s.in_valid && in_ready;
        out_data  = rst ? data_q[idx_q*OUT_WIDTH +: OUT_WIDTH] : '0;
        out_last  = last_q && at_last && out_valid;
    end

    assign s.out_valid  = out_valid;
    assign s.out_data   = out_data;
    assign s.out_last   = out_last;
    assign s.in_ready   = in_ready;
    assign busy         = out_valid;
    assign word_count   = word_count_q;
    assign beat_count   = beat_count_q;

    // Next-state: a load wins over an end-of-word return to IDLE, giving bubble-free reloads.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        last_d       = last_q;
        idx_d        = idx_q;
        word_count_d = word_count_q + CNT_WIDTH'(in_xfer);
        beat_count_d = beat_count_q + CNT_WIDTH'(out_xfer);
        if (in_xfer) begin
            data_d  = s.in_data;
            last_d  = s.in_last;
            idx_d   = '0;
            state_d = SHIFT;
        end else if (out_xfer) begin
            if (at_last) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset discarding any held word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            data_q       <= '0;
            last_q       <= 1'b0;
            idx_q        <= '0;
            word_count_q <= '0;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            word_count_q <= word_count_d;
            beat_count_q <= beat_count_d;
        end
    end
endmodule

// File: tb/tb_stream_width_serializer.sv
// Scoreboard testbench for stream_width_serializer.
// A second instance with 4-bit counters shadows the main one to observe counter wrap.
module tb_stream_width_serializer;
    localparam int IW    = 32;
    localparam int OW    = 8;
    localparam int RATIO = IW / OW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    stream_width_serializer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) sif ();
    stream_width_serializer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) wif ();

    logic [31:0] word_count, beat_count;
    logic        busy;
    logic [3:0]  wrap_word_count, wrap_beat_count;
    logic        wrap_busy;

    stream_width_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .s(sif),
        .word_count(word_count), .beat_count(beat_count), .busy(busy)
    );

    stream_width_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(4)) dut_wrap (
        .clk(clk), .rst(rst), .s(wif),
        .word_count(wrap_word_count), .beat_count(wrap_beat_count), .busy(wrap_busy)
    );

    assign wif.in_data   = sif.in_data;
    assign wif.in_valid  = sif.in_valid;
    assign wif.in_last   = sif.in_last;
    assign wif.out_ready = sif.out_ready;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    exp_words = 0;
    int    exp_beats = 0;
    int    cyc = 0;
    int    accept_cyc = 0;
    int    beats_seen = 0;
    int    first_beat_cyc = -1;
    int    last_beat_cyc = -1;
    bit    mark_first = 1'b0;
    bit    hold_pending = 1'b0;
    logic [OW-1:0] hold_data;
    logic          hold_last;
    int    ready_mode = 0;
    int    bp_step = 0;
    logic [3:0] bp_pat = 4'b1001;

    // Single comparison point; every failure is reported and counted here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Reference model: a word becomes RATIO slices, lowest first; only the final slice of a last word carries last.
    function automatic void pushModel(input logic [31:0] w, input logic l);
        for (int b = 0; b < RATIO; b++) begin
            beat_t e;
            e.data = OW'((w >> (OW * b)) & 32'hFF);
            e.last = l && (b == RATIO - 1);
            exp_q.push_back(e);
        end
        exp_words++;
    endfunction

    // Cycle counter used for latency and gap measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready generator: always ready, random, or the 1,0,0,1 backpressure pattern.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: sif.out_ready = 1'b1;
            1: sif.out_ready = 1'($urandom_range(0, 1));
            default: begin
                sif.out_ready = bp_pat[bp_step % 4];
                bp_step++;
            end
        endcase
    end

    // Monitor: checks stability under backpressure and pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (!rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checkOutput("hold_valid", 32'(sif.out_valid), 32'd1);
                checkOutput("hold_data", 32'(sif.out_data), 32'(hold_data));
                checkOutput("hold_last", 32'(sif.out_last), 32'(hold_last));
            end
            hold_pending = 1'b0;
            if (sif.out_valid && sif.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_beat: got data 0x%0h with nothing expected at cycle %0d", sif.out_data, cyc);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    checkOutput("beat_data", 32'(sif.out_data), 32'(e.data));
                    checkOutput("beat_last", 32'(sif.out_last), 32'(e.last));
                end
                beats_seen++;
                exp_beats++;
                if (mark_first) begin
                    first_beat_cyc = cyc;
                    mark_first = 1'b0;
                end
                last_beat_cyc = cyc;
            end else if (sif.out_valid) begin
                hold_pending = 1'b1;
                hold_data = sif.out_data;
                hold_last = sif.out_last;
            end
        end
    end

    // Offer one word and wait (bounded) for it to be accepted; returns #1 after the accepting edge with in_valid still high.
    task automatic applyStimulus(input logic [31:0] w, input logic l);
        int tries;
        tries = 0;
        sif.in_data  = w;
        sif.in_last  = l;
        sif.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (sif.in_ready) begin
                accept_cyc = cyc;
                pushModel(w, l);
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            tries++;
            if (tries > 200) begin
                total++;
                bad++;
                $display("[TB] FAIL accept_timeout: in_ready never rose for word 0x%0h", w);
                break;
            end
        end
    endtask

    // Withdraw the input for n cycles, scribbling on the data lines to show they are ignored.
    task automatic idleInput(input int n);
        sif.in_valid = 1'b0;
        sif.in_data  = $urandom;
        sif.in_last  = 1'($urandom_range(0, 1));
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) until every expected beat has left the DUT.
    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        @(posedge clk);
        #1;
        checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_word_count"}, word_count, 32'(exp_words));
        checkOutput({tag, "_beat_count"}, beat_count, 32'(exp_beats));
    endtask

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed and random sequences.
    initial begin
        int target;
        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.in_last   = 1'b0;
        sif.out_ready = 1'b1;

        // Reset for two cycles; outputs quiet throughout.
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(sif.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(sif.in_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_out_last", 32'(sif.out_last), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_word_count", word_count, 32'd0);
        checkOutput("rst_beat_count", beat_count, 32'd0);
        checkOutput("rst_out_data", 32'(sif.out_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single word, latency and counters.
        $display("[TB] single word");
        mark_first = 1'b1;
        applyStimulus(32'hDDCCBBAA, 1'b0);
        idleInput(1);
        drain();
        checkOutput("single_latency", 32'(first_beat_cyc), 32'(accept_cyc + 1));
        checkOutput("single_span", 32'(last_beat_cyc - first_beat_cyc), 32'(RATIO - 1));
        checkOutput("single_out_valid_after", 32'(sif.out_valid), 32'd0);
        checkOutput("single_word_count", word_count, 32'd1);
        checkOutput("single_beat_count", beat_count, 32'd4);

        // Back-to-back stream with no gaps.
        $display("[TB] back-to-back stream");
        mark_first = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] w;
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            applyStimulus(w, 1'b0);
        end
        idleInput(1);
        drain();
        checkOutput("stream_no_gap", 32'(last_beat_cyc - first_beat_cyc), 32'd31);
        checkCounters("stream");

        // Backpressure with the 1,0,0,1 pattern.
        $display("[TB] backpressure");
        bp_step = 0;
        ready_mode = 2;
        applyStimulus(32'h44332211, 1'b0);
        idleInput(1);
        drain();
        ready_mode = 0;
        checkCounters("bp");

        // Packet boundary on the middle word.
        $display("[TB] packet boundary");
        applyStimulus(32'h0000000A, 1'b0);
        applyStimulus(32'h0000000B, 1'b1);
        applyStimulus(32'h0000000C, 1'b0);
        idleInput(1);
        drain();

        // Random words, gaps and downstream readiness.
        $display("[TB] random traffic");
        ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            applyStimulus($urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idleInput($urandom_range(1, 3));
        end
        idleInput(1);
        drain();
        ready_mode = 0;
        idleInput(2);
        checkCounters("random");

        // Reset after two beats of a word; the rest must vanish.
        $display("[TB] reset mid-word");
        target = beats_seen + 2;
        applyStimulus(32'h87654321, 1'b0);
        idleInput(0);
        sif.in_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (beats_seen >= target) break;
            @(posedge clk);
        end
        checkOutput("midrst_beats_before", 32'(beats_seen), 32'(target));
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_words = 0;
        exp_beats = 0;
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(sif.out_valid), 32'd0);
        checkOutput("midrst_word_count", word_count, 32'd0);
        checkOutput("midrst_beat_count", beat_count, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(32'h0BADF00D, 1'b1);
        idleInput(1);
        drain();
        checkCounters("midrst_after");

        // Counter wrap on the 4-bit instance: 17 words since reset.
        $display("[TB] counter wrap");
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_words = 0;
        exp_beats = 0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus($urandom, 1'b0);
        end
        idleInput(1);
        drain();
        checkOutput("wrap_word_count", 32'(wrap_word_count), 32'(exp_words % 16));
        checkOutput("wrap_beat_count", 32'(wrap_beat_count), 32'(exp_beats % 16));
        checkOutput("wrap_main_words", word_count, 32'd17);
        checkOutput("wrap_main_beats", beat_count, 32'd68);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
